// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer for an 18-bit ISA: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Every control output is decoded from the state register and ir, never from inputs.
module instr_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [17:0]     instr,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            mem_ready,
    output logic [PC_W-1:0] pc,
    output logic [17:0]     ir,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            alu_src,
    output logic [2:0]      alu_op,
    output logic            zf,
    output logic            cf,
    output logic            halted,
    output logic            illegal
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_ANDI = 4'b0011;
    localparam logic [3:0] OP_NAND = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_LD   = 4'b0110;
    localparam logic [3:0] OP_ST   = 4'b0111;
    localparam logic [3:0] OP_JUMP = 4'b1000;
    localparam logic [3:0] OP_BEQ  = 4'b1001;
    localparam logic [3:0] OP_BNE  = 4'b1010;
    localparam logic [3:0] OP_BC   = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    state_t state, state_nxt;

    logic [3:0]      opcode;
    logic            is_alu, is_imm, is_ld, is_st, is_jump, is_branch, is_halt, is_illegal;
    logic            take_branch;
    logic [2:0]      op_sel;
    logic [PC_W-1:0] target;

    assign opcode = ir[17:14];
    assign target = PC_W'(ir[9:0]);

    always_comb begin
        is_alu      = 1'b0;
        is_imm      = 1'b0;
        is_ld       = 1'b0;
        is_st       = 1'b0;
        is_jump     = 1'b0;
        is_branch   = 1'b0;
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        take_branch = 1'b0;
        op_sel      = 3'b000;
        case (opcode)
            OP_ADD:  is_alu = 1'b1;
            OP_AND:  begin is_alu = 1'b1; op_sel = 3'b001; end
            OP_ADDI: begin is_alu = 1'b1; is_imm = 1'b1; end
            OP_ANDI: begin is_alu = 1'b1; is_imm = 1'b1; op_sel = 3'b001; end
            OP_NAND: begin is_alu = 1'b1; op_sel = 3'b010; end
            OP_NOR:  begin is_alu = 1'b1; op_sel = 3'b011; end
            OP_LD:   begin is_ld = 1'b1; is_imm = 1'b1; end
            OP_ST:   begin is_st = 1'b1; is_imm = 1'b1; end
            OP_JUMP: is_jump = 1'b1;
            OP_BEQ:  begin is_branch = 1'b1; take_branch = zf; end
            OP_BNE:  begin is_branch = 1'b1; take_branch = ~zf; end
            OP_BC:   begin is_branch = 1'b1; take_branch = cf; end
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 3'b000;
        halted     = 1'b0;
        illegal    = 1'b0;
        case (state)
            S_FETCH: state_nxt = S_DECODE;
            S_DECODE: begin
                if (is_halt)         state_nxt = S_HALT;
                else if (is_illegal) begin
                    state_nxt = S_FETCH;
                    illegal   = 1'b1;
                end
                else                 state_nxt = S_EXEC;
            end
            S_EXEC: begin
                alu_src = is_imm;
                alu_op  = op_sel;
                if (is_alu)              state_nxt = S_WB;
                else if (is_ld || is_st) state_nxt = S_MEM;
                else                     state_nxt = S_FETCH;
            end
            S_MEM: begin
                // Enable is held until the memory acknowledges.
                mem_read  = is_ld;
                mem_write = is_st;
                if (mem_ready) state_nxt = is_ld ? S_WB : S_FETCH;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_ld;
                alu_src    = is_imm;
                alu_op     = op_sel;
                state_nxt  = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nxt = S_FETCH;
        endcase
    end

    // Branch conditions read the flags as they stood entering EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
            zf <= 1'b0;
            cf <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ir <= instr;
                    pc <= pc + PC_W'(1);
                end
                S_EXEC: begin
                    if (is_alu) begin
                        zf <= alu_zero;
                        cf <= alu_carry;
                    end else if (is_jump || (is_branch && take_branch)) begin
                        pc <= target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle checks of controls, pc and flags.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [17:0] instr;
    logic        alu_zero, alu_carry, mem_ready;
    logic [9:0]  pc;
    logic [17:0] ir;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [2:0]  alu_op;
    logic        zf, cf, halted, illegal;

    logic [17:0] imem [0:1023];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    assign instr = imem[pc];

    instr_sequencer #(.PC_W(10), .RESET_PC(10'd0)) dut (
        .clk(clk), .reset(reset), .instr(instr),
        .alu_zero(alu_zero), .alu_carry(alu_carry), .mem_ready(mem_ready),
        .pc(pc), .ir(ir), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
        .alu_op(alu_op), .zf(zf), .cf(cf), .halted(halted), .illegal(illegal)
    );

    function automatic logic [17:0] enc(input logic [3:0] op, input logic [9:0] tgt);
        return {op, 4'b0000, tgt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 1 (FETCH) with reset released.
    task automatic do_reset();
        for (int i = 0; i < 1024; i++) imem[i] = 18'h0;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 10'd0 || ir !== 18'd0 || zf !== 1'b0 || cf !== 1'b0 ||
            halted !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pc=%h ir=%h zf=%b cf=%b halted=%b illegal=%b want all 0",
                     pc, ir, zf, cf, halted, illegal);
        end
        checks++;
        if ({reg_write, mem_read, mem_write, mem_to_reg, alu_src} !== 5'b0) begin
            errors++;
            $display("FAIL reset_enables got %b want 00000",
                     {reg_write, mem_read, mem_write, mem_to_reg, alu_src});
        end
    endtask

    task automatic test_addi_add();
        do_reset();
        imem[0] = enc(4'b0010, 10'h011);
        imem[1] = enc(4'b0000, 10'h022);
        for (int c = 1; c <= 9; c++) begin
            alu_zero = (c == 7);
            checks++;
            if (reg_write !== (c == 4 || c == 8)) begin
                errors++;
                $display("FAIL aa_reg_write c%0d got %b want %b", c, reg_write, (c == 4 || c == 8));
            end
            if (c == 4 || c == 8) begin
                checks++;
                if (alu_src !== (c == 4)) begin
                    errors++;
                    $display("FAIL aa_alu_src c%0d got %b want %b", c, alu_src, (c == 4));
                end
            end
            if (c == 5) begin
                checks++;
                if (zf !== 1'b0) begin
                    errors++;
                    $display("FAIL aa_zf_after_addi got %b want 0", zf);
                end
            end
            tick();
        end
        checks++;
        if (zf !== 1'b1 || pc !== 10'd3) begin
            errors++;
            $display("FAIL aa_final got zf=%b pc=%0d want zf=1 pc=3", zf, pc);
        end
    endtask

    task automatic test_alu_ops();
        logic [3:0] ops  [4] = '{4'b0001, 4'b0011, 4'b0100, 4'b0101};
        logic [2:0] aops [4] = '{3'b001, 3'b001, 3'b010, 3'b011};
        logic       srcs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            do_reset();
            imem[0]   = enc(ops[k], 10'h3C5);
            alu_carry = 1'b1;
            tick();
            tick();
            checks++;
            if (alu_op !== aops[k] || alu_src !== srcs[k] || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_exec got alu_op=%b src=%b rw=%b want %b %b 0",
                         k, alu_op, alu_src, reg_write, aops[k], srcs[k]);
            end
            tick();
            checks++;
            if (reg_write !== 1'b1 || mem_to_reg !== 1'b0 || alu_op !== aops[k] || alu_src !== srcs[k]) begin
                errors++;
                $display("FAIL op%0d_wb got rw=%b m2r=%b alu_op=%b src=%b want 1 0 %b %b",
                         k, reg_write, mem_to_reg, alu_op, alu_src, aops[k], srcs[k]);
            end
            tick();
            checks++;
            if (cf !== 1'b1 || zf !== 1'b0 || pc !== 10'd1 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL op%0d_after got cf=%b zf=%b pc=%0d rw=%b want 1 0 1 0",
                         k, cf, zf, pc, reg_write);
            end
        end
    endtask

    task automatic test_load();
        do_reset();
        imem[0] = enc(4'b0110, 10'h005);
        for (int c = 1; c <= 9; c++) begin
            // Ready high in FETCH/DECODE/EXEC must be ignored.
            mem_ready = (c <= 3) || (c == 7);
            checks++;
            if (mem_read !== (c >= 4 && c <= 7) || mem_write !== 1'b0) begin
                errors++;
                $display("FAIL ld_mem c%0d got rd=%b wr=%b want rd=%b wr=0",
                         c, mem_read, mem_write, (c >= 4 && c <= 7));
            end
            checks++;
            if (reg_write !== (c == 8) || mem_to_reg !== (c == 8)) begin
                errors++;
                $display("FAIL ld_wb c%0d got rw=%b m2r=%b want %b", c, reg_write, mem_to_reg, (c == 8));
            end
            if (c == 3) begin
                checks++;
                if (alu_src !== 1'b1 || alu_op !== 3'b000) begin
                    errors++;
                    $display("FAIL ld_exec got src=%b op=%b want 1 000", alu_src, alu_op);
                end
            end
            tick();
        end
        checks++;
        if (pc !== 10'd2 || ir !== 18'h0) begin
            errors++;
            $display("FAIL ld_next got pc=%0d ir=%h want 2 0", pc, ir);
        end
    endtask

    task automatic test_store();
        do_reset();
        imem[0] = enc(4'b0111, 10'h009);
        for (int c = 1; c <= 6; c++) begin
            mem_ready = (c == 5);
            checks++;
            if (mem_write !== (c == 4 || c == 5) || mem_read !== 1'b0 || reg_write !== 1'b0) begin
                errors++;
                $display("FAIL st c%0d got wr=%b rd=%b rw=%b want wr=%b rd=0 rw=0",
                         c, mem_write, mem_read, reg_write, (c == 4 || c == 5));
            end
            tick();
        end
        checks++;
        if (pc !== 10'd2) begin
            errors++;
            $display("FAIL st_next got pc=%0d want 2", pc);
        end
    endtask

    task automatic test_branch();
        do_reset();
        alu_zero     = 1'b1;
        imem[0]      = enc(4'b0000, 10'h000);
        imem[1]      = enc(4'b1001, 10'h155);
        imem[10'h155] = enc(4'b1010, 10'h000);
        imem[10'h156] = enc(4'b1011, 10'h200);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (pc !== 10'h155 || zf !== 1'b1) begin
            errors++;
            $display("FAIL beq_taken got pc=%h zf=%b want 155 1", pc, zf);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc !== 10'h156) begin
            errors++;
            $display("FAIL bne_not_taken got pc=%h want 156", pc);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc !== 10'h157 || zf !== 1'b1 || cf !== 1'b0) begin
            errors++;
            $display("FAIL bc_not_taken got pc=%h zf=%b cf=%b want 157 1 0", pc, zf, cf);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        imem[0]      = enc(4'b1000, 10'h3FF);
        imem[10'h3FF] = enc(4'b0000, 10'h02A);
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (pc !== 10'h3FF) begin
            errors++;
            $display("FAIL jump_3ff got pc=%h want 3ff", pc);
        end
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (pc !== 10'h000 || ir !== enc(4'b0000, 10'h02A)) begin
            errors++;
            $display("FAIL pc_wrap got pc=%h ir=%h want 000 %h", pc, ir, enc(4'b0000, 10'h02A));
        end
    endtask

    task automatic test_illegal_halt();
        do_reset();
        imem[0] = enc(4'b1101, 10'h001);
        imem[1] = enc(4'b1111, 10'h0AB);
        for (int c = 1; c <= 3; c++) begin
            checks++;
            if (illegal !== (c == 2) || {reg_write, mem_read, mem_write} !== 3'b000) begin
                errors++;
                $display("FAIL illegal c%0d got ill=%b en=%b want ill=%b en=000",
                         c, illegal, {reg_write, mem_read, mem_write}, (c == 2));
            end
            tick();
        end
        tick();
        for (int c = 0; c < 22; c++) begin
            mem_ready = c[0];
            alu_zero  = 1'b1;
            checks++;
            if (halted !== 1'b1 || pc !== 10'd2 || ir !== enc(4'b1111, 10'h0AB) || zf !== 1'b0 ||
                {reg_write, mem_read, mem_write} !== 3'b000) begin
                errors++;
                $display("FAIL halt_hold c%0d got halted=%b pc=%0d ir=%h zf=%b en=%b want 1 2 %h 0 000",
                         c, halted, pc, ir, zf, {reg_write, mem_read, mem_write}, enc(4'b1111, 10'h0AB));
            end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (halted !== 1'b0 || pc !== 10'd0 || ir !== 18'd0) begin
            errors++;
            $display("FAIL halt_reset got halted=%b pc=%0d ir=%h want 0 0 0", halted, pc, ir);
        end
    endtask

    task automatic test_reset_in_mem();
        do_reset();
        imem[0] = enc(4'b0111, 10'h033);
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rmem_pending got wr=%b want 1", mem_write);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (mem_write !== 1'b0 || pc !== 10'd0 || ir !== 18'd0) begin
            errors++;
            $display("FAIL rmem_abort got wr=%b pc=%0d ir=%h want 0 0 0", mem_write, pc, ir);
        end
        tick();
        checks++;
        if (mem_write !== 1'b0 || pc !== 10'd1 || ir !== enc(4'b0111, 10'h033)) begin
            errors++;
            $display("FAIL rmem_refetch got wr=%b pc=%0d ir=%h want 0 1 %h",
                     mem_write, pc, ir, enc(4'b0111, 10'h033));
        end
    endtask

    initial begin
        reset     = 1'b1;
        alu_zero  = 1'b0;
        alu_carry = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_addi_add();
        test_alu_ops();
        test_load();
        test_store();
        test_branch();
        test_wrap();
        test_illegal_halt();
        test_reset_in_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter PC_W, default 10: program-counter width.
REQ-002 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 instr  input  18  instruction-memory read data for address pc.
REQ-006 alu_zero  input  1  ALU zero result, valid during EXEC.
REQ-007 alu_carry  input  1  ALU carry-out, valid during EXEC.
REQ-008 mem_ready  input  1  data memory has completed the current read/write.
REQ-009 pc  output  PC_W  registered program counter.
REQ-010 ir  output  18  registered instruction register.
REQ-011 reg_write, mem_read, mem_write, mem_to_reg, alu_src  output  1 each  datapath controls.
REQ-012 alu_op  output  3  ALU function: 000 ADD, 001 AND, 010 NAND, 011 NOR.
REQ-013 zf, cf  output  1 each  registered flags; halted, illegal  output  1 each  status.

Function
REQ-014 The opcode SHALL be ir[17:14], decoded as: 0000 ADD, 0001 AND, 0010 ADDI, 0011 ANDI, 0100 NAND, 0101 NOR, 0110 LD, 0111 ST, 1000 JUMP, 1001 BEQ, 1010 BNE, 1011 BC, 1111 HALT, 1100-1110 illegal.
REQ-015 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-016 FETCH: ir <= instr; pc <= pc+1 modulo 2^PC_W (1023 wraps to 0); next DECODE.
REQ-017 DECODE: next HALT for 1111; FETCH for illegal opcodes, pulsing illegal for exactly this cycle; otherwise EXEC.
REQ-018 EXEC, ALU ops (ADD/AND/ADDI/ANDI/NAND/NOR): zf <= alu_zero, cf <= alu_carry; next WB.
REQ-019 EXEC, LD/ST: alu_op=000, alu_src=1 (address = rs + imm); flags unchanged; next MEM.
REQ-020 EXEC, JUMP: pc <= ir[9:0]; next FETCH.
REQ-021 EXEC, BEQ/BNE/BC: pc <= ir[9:0] if zf=1 / zf=0 / cf=1 respectively (flags as held before this EXEC), else pc unchanged; next FETCH.
REQ-022 MEM: LD asserts mem_read, ST asserts mem_write, held every cycle until mem_ready=1; on mem_ready=1 LD goes to WB, ST goes to FETCH; mem_ready outside MEM SHALL be ignored.
REQ-023 WB: reg_write=1 for exactly one cycle; mem_to_reg=1 for LD, 0 for ALU ops; next FETCH.
REQ-024 alu_src SHALL be 1 in EXEC/WB for ADDI, ANDI, LD, ST and 0 otherwise; alu_op SHALL follow opcode (ADD/ADDI 000, AND/ANDI 001, NAND 010, NOR 011) in EXEC and WB.
REQ-025 All control outputs SHALL be decoded from registered state and ir only; no combinational path from any input to any output.
REQ-026 reg_write, mem_read, mem_write SHALL be 0 in FETCH, DECODE, HALT and never asserted simultaneously.
REQ-027 Latency in cycles: ALU op 4, ST 4+wait, LD 5+wait, JUMP/branch 3, illegal 2 (wait = cycles in MEM with mem_ready=0).
REQ-028 HALT: halted=1, pc/ir/flags frozen, all write/read enables 0; exit only by reset.

Reset
REQ-029 When reset=1 at a rising edge, the next state SHALL be FETCH with pc=RESET_PC, ir=0, zf=0, cf=0, halted=0, illegal=0, and all enables 0.
REQ-030 Reset SHALL take priority over every state including MEM with a pending access and HALT; the aborted access SHALL NOT be retried.

Verification
REQ-031 ADDI then ADD with alu_zero=1 in ADD's EXEC -> reg_write pulses at cycles 4 and 8 after reset release, alu_src 1 then 0, zf=1 afterwards.
REQ-032 LD with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then one WB cycle with mem_to_reg=1, reg_write=1; total 8 cycles.
REQ-033 zf=1, BEQ to 0x155 then BNE to 0x000 -> pc=0x155 after BEQ; BNE not taken, pc=0x156.
REQ-034 pc=1023 executing ADD -> pc wraps to 0; JUMP at 0 to 0x3FF -> pc=1023.
REQ-035 Opcode 1101 -> illegal high one cycle, no enables, next FETCH; opcode 1111 -> halted=1 held 20+ cycles, pc frozen.
REQ-036 reset asserted during MEM of ST with mem_ready=0 -> mem_write 0 on next cycle, pc=RESET_PC, state FETCH.
